instr_fetch: RTL and testbench

Instruction fetch stage, directly upstream of the instruction decoder. It holds the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. It buffers returned words with their PC in a small queue, presents them to decode over valid/ready, and services redirects from execute (taken branches, JAL/JALR) by flushing stale work.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fetch_queue.sv | 79 +++++++
 rtl/instr_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and the decoder.
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0), shown when no instruction is valid
//   opcode consts  : 7-bit major opcodes the decoder dispatches on
//   fetch_state_e  : fetch FSM encoding (IDLE=0, REQ=1, WAIT=2, DROP=3)
//   fetch_entry_t  : one buffered fetch result {instruction word, its PC}
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BTYPE    = 7'b1100011;
    localparam logic [6:0] LOADS    = 7'b0000011;
    localparam logic [6:0] STORES   = 7'b0100011;
    localparam logic [6:0] ARITHM_I = 7'b0010011;
    localparam logic [6:0] ARITHM_R = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {instruction, PC} pairs between memory and decode.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push       : write data_in at the tail
//   pop        : drop the head entry
//   flush      : empty the queue; overrides a concurrent push/pop
//   data_in    : entry to write
//   data_out   : current head entry (straight from storage registers)
//   count      : number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_en;
    logic             push_en;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign pop_en  = pop && (count_q != '0);
    assign push_en = push && ((count_q != CW'(DEPTH)) || pop_en);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, buffers responses with their PC and hands them to decode.
//   CLK, RST_N             : clock, asynchronous active-low reset
//   IMEM_REQ/ADDR/GNT      : request handshake, address held until granted
//   IMEM_RVALID/RDATA      : response, at least one cycle after the grant
//   REDIRECT/REDIRECT_PC   : one-cycle redirect from execute, flushes stale work
//   INSTR/INSTR_PC         : head of the fetch queue (NOP / last PC when empty)
//   INSTR_VALID/READY      : decode handshake
//   ALIGN_ERR              : one-cycle pulse after a misaligned redirect target
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic        ALIGN_ERR
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          align_err_q, align_err_d;
    logic [31:0]   last_pc_q;

    logic [CW-1:0] q_count;
    fetch_entry_t  q_head;
    fetch_entry_t  q_in;
    logic          q_push;
    logic          q_pop;
    logic          q_valid;
    logic [CW:0]   inflight;
    logic          credit_ok;
    logic          grant;

    // Never request more than the queue can absorb, counting the in-flight word.
    assign inflight  = {1'b0, q_count} + {{CW{1'b0}}, outstanding_q};
    assign credit_ok = inflight < (CW + 1)'(QDEPTH);

    assign IMEM_REQ  = (state_q == REQ) && credit_ok;
    assign IMEM_ADDR = pc_q;
    assign grant     = IMEM_REQ && IMEM_GNT;

    assign q_valid = (q_count != '0);
    assign q_pop   = q_valid && INSTR_READY;
    assign q_in    = '{instr: IMEM_RDATA, pc: req_pc_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        q_push        = 1'b0;
        align_err_d   = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (grant) begin
                    state_d       = WAIT;
                    outstanding_d = 1'b1;
                    req_pc_d      = pc_q;
                    pc_d          = pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (IMEM_RVALID) begin
                    q_push        = 1'b1;
                    outstanding_d = 1'b0;
                    state_d       = REQ;
                end
            end
            DROP: begin
                if (IMEM_RVALID) begin
                    outstanding_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins: new PC, nothing pushed, and any word still owed by
        // memory becomes stale so it must be swallowed in DROP. A response
        // arriving in the same cycle retires the owed word, so DROP is skipped.
        if (REDIRECT) begin
            pc_d   = {REDIRECT_PC[31:2], 2'b00};
            q_push = 1'b0;
            if (state_q == IDLE) begin
                state_d = IDLE;
            end else if ((state_q == REQ) && grant) begin
                state_d = DROP;
            end else if ((state_q == WAIT) && !IMEM_RVALID) begin
                state_d = DROP;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            align_err_q   <= 1'b0;
            last_pc_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            align_err_q   <= align_err_d;
            last_pc_q     <= INSTR_PC;
        end
    end

    fetch_queue #(
        .WIDTH (64),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (q_push),
        .pop      (q_pop),
        .flush    (REDIRECT),
        .data_in  (q_in),
        .data_out (q_head),
        .count    (q_count)
    );

    // When empty, decode sees a NOP while the PC output keeps its last value.
    assign INSTR_VALID = q_valid;
    assign INSTR       = q_valid ? q_head.instr : NOP_INSTR;
    assign INSTR_PC    = q_valid ? q_head.pc    : last_pc_q;
    assign ALIGN_ERR   = align_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, decode scoreboard,
// table of redirect scenarios and hand-written multi-cycle sequences.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int QD = 4;

    logic        CLK;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        ALIGN_ERR;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QD)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .ALIGN_ERR   (ALIGN_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] tgt2;
        int          mode;
        logic [31:0] exp_addr;
        logic        exp_align;
    } redir_vec_t;

    exp_t        exp_q[$];
    redir_vec_t  vecs[6];

    int          n_checks;
    int          n_fail;
    bit          gnt_en, ready_now, redir_now, align_exp, pend_valid, pend_stale;
    int          lat, pend_cnt, grants, g0;
    logic [31:0] redir_tgt, model_pc, pend_addr, last_head_pc, last_grant_addr;
    logic [31:0] hold_instr, hold_pc, a0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        pend_valid   = 0;
        pend_stale   = 0;
        pend_cnt     = 0;
        model_pc     = 32'h0;
        last_head_pc = 32'h0;
        align_exp    = 0;
        redir_now    = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   IMEM_REQ,    1'b0);
        check("rst_addr",  IMEM_ADDR,   32'h0);
        check("rst_valid", INSTR_VALID, 1'b0);
        check("rst_instr", INSTR,       NOP_INSTR);
        check("rst_pc",    INSTR_PC,    32'h0);
        check("rst_align", ALIGN_ERR,   1'b0);
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next
    // rising edge, update the memory model and scoreboard, advance a cycle.
    task automatic step();
        bit resp_now;
        check("instr_valid", INSTR_VALID, (exp_q.size() != 0));
        check("align_err", ALIGN_ERR, align_exp);
        if (exp_q.size() != 0) begin
            last_head_pc = exp_q[0].pc;
            check("instr", INSTR, exp_q[0].instr);
            check("instr_pc", INSTR_PC, exp_q[0].pc);
        end else begin
            check("instr_nop", INSTR, NOP_INSTR);
            check("instr_pc_hold", INSTR_PC, last_head_pc);
        end
        if (IMEM_REQ) check("imem_addr", IMEM_ADDR, model_pc);

        REDIRECT    = redir_now;
        REDIRECT_PC = redir_tgt;
        INSTR_READY = ready_now;
        IMEM_GNT    = gnt_en;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        resp_now    = 0;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                resp_now    = 1;
                pend_valid  = 0;
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = mem_word(pend_addr);
            end
        end
        if (exp_q.size() != 0 && ready_now && !redir_now) void'(exp_q.pop_front());
        if (resp_now && !pend_stale && !redir_now)
            exp_q.push_back('{instr: mem_word(pend_addr), pc: pend_addr});
        if (IMEM_REQ && gnt_en) begin
            grants++;
            last_grant_addr = IMEM_ADDR;
            pend_valid = 1;
            pend_cnt   = lat;
            pend_addr  = model_pc;
            pend_stale = redir_now;
            model_pc   = model_pc + 32'd4;
        end
        if (redir_now) begin
            exp_q.delete();
            if (pend_valid) pend_stale = 1;
            model_pc  = {redir_tgt[31:2], 2'b00};
            align_exp = |redir_tgt[1:0];
        end else begin
            align_exp = 0;
        end
        redir_now = 0;
        @(negedge CLK);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!IMEM_REQ && n < 30) begin
            step();
            n++;
        end
        check("wait_req_timeout", IMEM_REQ, 1'b1);
    endtask

    task automatic wait_grant(input string name, input logic [31:0] exp);
        int n = 0;
        int g = grants;
        while (grants == g && n < 30) begin
            step();
            n++;
        end
        check(name, (grants != g) ? last_grant_addr : 32'hDEAD_DEAD, exp);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp);
        int n = 0;
        while (!INSTR_VALID && n < 30) begin
            step();
            n++;
        end
        check(name, INSTR_VALID ? INSTR_PC : 32'hDEAD_DEAD, exp);
    endtask

    task automatic do_reset();
        #2;
        RST_N       = 1'b0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        REDIRECT    = 1'b0;
        INSTR_READY = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge CLK);
        @(negedge CLK);
        reset_model();
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tgt: 32'h0000_0100, tgt2: 32'h0, mode: 1, exp_addr: 32'h0000_0100, exp_align: 1'b0};
        vecs[1] = '{tgt: 32'h0000_0203, tgt2: 32'h0, mode: 0, exp_addr: 32'h0000_0200, exp_align: 1'b1};
        vecs[2] = '{tgt: 32'h0000_0340, tgt2: 32'h0, mode: 2, exp_addr: 32'h0000_0340, exp_align: 1'b0};
        vecs[3] = '{tgt: 32'h0000_0401, tgt2: 32'h0, mode: 3, exp_addr: 32'h0000_0400, exp_align: 1'b1};
        vecs[4] = '{tgt: 32'h0000_0500, tgt2: 32'h0000_0600, mode: 4, exp_addr: 32'h0000_0600, exp_align: 1'b0};
        vecs[5] = '{tgt: 32'hFFFF_FFFE, tgt2: 32'h0, mode: 0, exp_addr: 32'hFFFF_FFFC, exp_align: 1'b1};

        n_checks = 0;
        n_fail   = 0;
        grants   = 0;
        RST_N = 1'b0;
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INSTR_READY = 1'b0;
        gnt_en = 1; ready_now = 1; lat = 1; redir_tgt = 32'h0;
        last_grant_addr = 32'h0;
        reset_model();
        repeat (2) @(negedge CLK);
        check_reset_outputs();
        RST_N = 1'b1;

        // Sequential fetch with one-cycle memory.
        step();
        check("idle_to_req", IMEM_REQ, 1'b1);
        step();
        check("first_addr", last_grant_addr, 32'h0);
        check("nop_before_resp", INSTR, NOP_INSTR);
        step();
        check("first_instr", INSTR, mem_word(32'h0));
        check("first_pc", INSTR_PC, 32'h0);
        step();
        check("second_addr", last_grant_addr, 32'h4);
        step();
        step();
        check("third_addr", last_grant_addr, 32'h8);
        repeat (6) step();

        // Backpressure from a fresh start.
        do_reset();
        step();
        ready_now = 0;
        g0 = grants;
        repeat (10) step();
        check("stall_grants", grants - g0, QD);
        check("stall_req_low", IMEM_REQ, 1'b0);
        hold_instr = INSTR;
        hold_pc    = INSTR_PC;
        step();
        step();
        check("stall_instr_stable", INSTR, hold_instr);
        check("stall_pc_stable", INSTR_PC, hold_pc);
        ready_now = 1;
        repeat (20) step();
        check("resume_fetch", ((grants - g0) >= QD + 3) ? 1 : 0, 1);

        // Grant withheld for three cycles.
        wait_req();
        gnt_en = 0;
        a0 = IMEM_ADDR;
        g0 = grants;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gnt_low_req", IMEM_REQ, 1'b1);
            check("gnt_low_addr", IMEM_ADDR, a0);
        end
        gnt_en = 1;
        step();
        check("single_grant", grants - g0, 1);
        check("req_drops_in_wait", IMEM_REQ, 1'b0);
        repeat (4) step();

        // Redirect scenarios.
        for (int v = 0; v < 6; v++) begin
            gnt_en = 1;
            lat = (vecs[v].mode == 1) ? 2 : (vecs[v].mode == 4) ? 3 : 1;
            if (vecs[v].mode == 2) gnt_en = 0;
            wait_req();
            if (vecs[v].mode == 1 || vecs[v].mode == 3 || vecs[v].mode == 4) step();
            redir_now = 1;
            redir_tgt = vecs[v].tgt;
            step();
            if (vecs[v].mode == 4) begin
                redir_now = 1;
                redir_tgt = vecs[v].tgt2;
                step();
            end
            gnt_en = 1;
            check("redir_valid_cleared", INSTR_VALID, 1'b0);
            check("redir_align", ALIGN_ERR, vecs[v].exp_align);
            wait_grant("redir_next_addr", vecs[v].exp_addr);
            wait_valid("redir_first_pc", vecs[v].exp_addr);
            wait_grant("redir_following_addr", vecs[v].exp_addr + 32'd4);
            lat = 1;
            repeat (4) step();
        end

        // Asynchronous reset while a request is outstanding and 2 words are queued.
        do_reset();
        step();
        ready_now = 0;
        lat = 2;
        g0 = grants;
        for (int n = 0; n < 20 && grants < g0 + 3; n++) step();
        check("pre_reset_grants", grants - g0, 3);
        check("pre_reset_valid", INSTR_VALID, 1'b1);
        do_reset();
        lat = 1;
        ready_now = 1;
        wait_grant("restart_addr", 32'h0);
        wait_valid("restart_pc", 32'h0);
        check("restart_instr", INSTR, mem_word(32'h0));
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
